csr_trap_unit: RTL and testbench

Machine-mode CSR file and trap controller for the RV32 core, the successor to the basic CSR block. It adds full trap entry/exit semantics (mstatus MIE/MPIE stacking, mret), mtval, vectored mtvec, three prioritised machine interrupts, illegal-access detection, and optional 64-bit cycle/instret counters. It sits beside the execute stage: it reads and writes CSRs for Zicsr instructions and supplies the redirect PC for traps and mret.

---
 rtl/csr_trap_unit_pkg.sv | 88 ++++++++
 rtl/csr_trap_unit_counter64.sv | 37 +++
 rtl/csr_trap_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_unit_pkg
// Description : Shared constants for the machine-mode CSR file and trap
//               controller: CSR addresses, mcause codes, mstatus/mip bit
//               positions, csr_op encodings and the operation decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_trap_unit_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] c_CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] c_CSR_MISA      = 12'h301;
    localparam logic [11:0] c_CSR_MIE       = 12'h304;
    localparam logic [11:0] c_CSR_MTVEC     = 12'h305;
    localparam logic [11:0] c_CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_CSR_MEPC      = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] c_CSR_MTVAL     = 12'h343;
    localparam logic [11:0] c_CSR_MIP       = 12'h344;
    localparam logic [11:0] c_CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] c_CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] c_CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] c_CSR_MHARTID   = 12'hF14;

    // Counter addresses (only decoded when counters are built in)
    localparam logic [11:0] c_CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] c_CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] c_CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] c_CSR_INSTRETH  = 12'hC82;

    // Synchronous exception cause codes
    localparam logic [3:0] c_MCAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] c_MCAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] c_MCAUSE_ECALL_M    = 4'd11;

    // Interrupt cause codes
    localparam logic [3:0] c_IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] c_IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] c_IRQ_CODE_MEI = 4'd11;

    // mstatus bit positions
    localparam int c_MSTATUS_MIE_BIT  = 3;
    localparam int c_MSTATUS_MPIE_BIT = 7;
    localparam int c_MSTATUS_MPP_LO   = 11;
    localparam int c_MSTATUS_MPP_HI   = 12;

    // mip / mie bit positions
    localparam int c_MIP_MSI_BIT = 3;
    localparam int c_MIP_MTI_BIT = 7;
    localparam int c_MIP_MEI_BIT = 11;

    // Writable bits of mie
    localparam logic [31:0] c_IRQ_MASK = 32'h0000_0888;

    // csr_op encodings
    localparam logic [2:0] c_CSR_OP_RW  = 3'd1;
    localparam logic [2:0] c_CSR_OP_RS  = 3'd2;
    localparam logic [2:0] c_CSR_OP_RC  = 3'd3;
    localparam logic [2:0] c_CSR_OP_RWI = 3'd5;
    localparam logic [2:0] c_CSR_OP_RSI = 3'd6;
    localparam logic [2:0] c_CSR_OP_RCI = 3'd7;

    // Decoded CSR operation, independent of operand source
    typedef enum logic [1:0] {
        CSR_FN_NONE  = 2'd0,
        CSR_FN_WRITE = 2'd1,
        CSR_FN_SET   = 2'd2,
        CSR_FN_CLEAR = 2'd3
    } csr_fn_e;

    function automatic csr_fn_e csr_decode_fn(input logic [2:0] op);
        csr_fn_e fn;
        case (op)
            c_CSR_OP_RW, c_CSR_OP_RWI: fn = CSR_FN_WRITE;
            c_CSR_OP_RS, c_CSR_OP_RSI: fn = CSR_FN_SET;
            c_CSR_OP_RC, c_CSR_OP_RCI: fn = CSR_FN_CLEAR;
            default:                   fn = CSR_FN_NONE;
        endcase
        return fn;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_trap_unit_counter64.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter64
// Description : 64-bit free-running counter with increment enable and a
//               per-half write port. A write to either half suppresses the
//               increment for the whole counter that cycle; the unwritten
//               half holds its value.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    // Counter register: write beats increment, carry spans both halves
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) r_count[31:0]  <= i_wdata;
            if (i_wr_hi) r_count[63:32] <= i_wdata;
        end else if (i_inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_unit
// Description : Machine-mode CSR file and trap controller. Handles Zicsr
//               reads/writes, trap entry (exceptions and three prioritised
//               machine interrupts), mret, and supplies redirect PCs.
//               Optional 64-bit cycle/instret counters are built in when the
//               macro CSR_COUNTERS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic [11:0] i_csr_addr,
    input  logic [2:0]  i_csr_op,
    input  logic        i_csr_we,
    input  logic [31:0] i_rs1_data,
    input  logic [4:0]  i_zimm,
    output logic [31:0] o_csr_rdata,
    output logic        o_illegal,
    input  logic        i_except_en,
    input  logic [3:0]  i_except_code,
    input  logic [31:0] i_except_pc,
    input  logic [31:0] i_except_tval,
    input  logic        i_mret,
    input  logic        i_retire,
    input  logic        i_irq_ext,
    input  logic        i_irq_timer,
    input  logic        i_irq_soft,
    output logic        o_irq_take,
    output logic [31:0] o_trap_vector,
    output logic [31:0] o_epc
);

    // Architectural state
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_mie;
    logic [31:0] r_mscratch;

    // Derived views and decode
    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic [31:0] w_pending;
    logic [3:0]  w_irq_code;
    logic [31:0] w_base;
    logic [31:0] w_rdata;
    logic        w_impl;
    logic        w_readonly;
    logic [31:0] w_src;
    logic [31:0] w_wval;
    logic        w_wants;
    logic        w_csr_wr;
    logic        w_trap;
    logic        w_trap_irq;
    logic [3:0]  w_trap_code;

`ifdef CSR_COUNTERS_EN
    logic [63:0] w_cycle;
    logic [63:0] w_instret;
`else
    logic        w_unused_retire;
`endif

    // Packed views of mstatus (MPP hard-wired to machine mode) and mip
    always_comb begin
        w_mstatus                                      = '0;
        w_mstatus[c_MSTATUS_MIE_BIT]                   = r_mstatus_mie;
        w_mstatus[c_MSTATUS_MPIE_BIT]                  = r_mstatus_mpie;
        w_mstatus[c_MSTATUS_MPP_HI:c_MSTATUS_MPP_LO]   = 2'b11;
        w_mip                                          = '0;
        w_mip[c_MIP_MEI_BIT]                           = i_irq_ext;
        w_mip[c_MIP_MTI_BIT]                           = i_irq_timer;
        w_mip[c_MIP_MSI_BIT]                           = i_irq_soft;
    end

    // Interrupt selection: MEI beats MSI beats MTI
    always_comb begin
        w_pending = r_mie & w_mip;
        if (w_pending[c_MIP_MEI_BIT])      w_irq_code = c_IRQ_CODE_MEI;
        else if (w_pending[c_MIP_MSI_BIT]) w_irq_code = c_IRQ_CODE_MSI;
        else                               w_irq_code = c_IRQ_CODE_MTI;
    end

    // An interrupt is only taken when nothing higher priority claims the cycle
    assign o_irq_take = ~i_stall & ~i_except_en & r_mstatus_mie & (|w_pending);

    // Redirect targets; vectored mode offsets only interrupts
    assign w_base        = {r_mtvec[31:2], 2'b00};
    assign o_trap_vector = (o_irq_take && r_mtvec[0])
                         ? w_base + {26'd0, w_irq_code, 2'b00}
                         : w_base;
    assign o_epc         = r_mepc;

    // CSR read mux; anything not listed is unimplemented
    always_comb begin
        w_rdata = '0;
        w_impl  = 1'b1;
        case (i_csr_addr)
            c_CSR_MSTATUS:   w_rdata = w_mstatus;
            c_CSR_MISA:      w_rdata = MISA_VALUE;
            c_CSR_MIE:       w_rdata = r_mie;
            c_CSR_MTVEC:     w_rdata = r_mtvec;
            c_CSR_MSCRATCH:  w_rdata = r_mscratch;
            c_CSR_MEPC:      w_rdata = r_mepc;
            c_CSR_MCAUSE:    w_rdata = r_mcause;
            c_CSR_MTVAL:     w_rdata = r_mtval;
            c_CSR_MIP:       w_rdata = w_mip;
            c_CSR_MVENDORID,
            c_CSR_MARCHID,
            c_CSR_MIMPID:    w_rdata = '0;
            c_CSR_MHARTID:   w_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            c_CSR_MCYCLE,
            c_CSR_CYCLE:     w_rdata = w_cycle[31:0];
            c_CSR_MCYCLEH,
            c_CSR_CYCLEH:    w_rdata = w_cycle[63:32];
            c_CSR_MINSTRET,
            c_CSR_INSTRET:   w_rdata = w_instret[31:0];
            c_CSR_MINSTRETH,
            c_CSR_INSTRETH:  w_rdata = w_instret[63:32];
`endif
            default:         w_impl  = 1'b0;
        endcase
    end

    assign o_csr_rdata = w_rdata;
    assign w_readonly  = (i_csr_addr[11:10] == 2'b11);

    // Write-value computation; set/clear with a zero operand is a pure read
    always_comb begin
        w_src   = i_csr_op[2] ? {27'd0, i_zimm} : i_rs1_data;
        w_wval  = w_rdata;
        w_wants = 1'b0;
        case (csr_decode_fn(i_csr_op))
            CSR_FN_WRITE: begin
                w_wval  = w_src;
                w_wants = 1'b1;
            end
            CSR_FN_SET: begin
                w_wval  = w_rdata | w_src;
                w_wants = |w_src;
            end
            CSR_FN_CLEAR: begin
                w_wval  = w_rdata & ~w_src;
                w_wants = |w_src;
            end
            default: begin
                w_wval  = w_rdata;
                w_wants = 1'b0;
            end
        endcase
    end

    assign o_illegal = i_csr_we & (~w_impl | (w_readonly & w_wants));

    // Event arbitration: stall > exception > interrupt > mret > CSR write
    assign w_trap      = ~i_stall & (i_except_en | o_irq_take);
    assign w_trap_irq  = ~i_except_en;
    assign w_trap_code = i_except_en ? i_except_code : w_irq_code;
    assign w_csr_wr    = i_csr_we & w_wants & ~o_illegal & ~i_stall
                       & ~i_except_en & ~o_irq_take & ~i_mret;

    // Architectural CSR state update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mtvec        <= MTVEC_RESET & ~32'h2;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
            r_mie          <= '0;
            r_mscratch     <= '0;
        end else if (w_trap) begin
            r_mepc         <= i_except_pc & ~32'h3;
            r_mcause       <= {w_trap_irq, 27'd0, w_trap_code};
            r_mtval        <= i_except_en ? i_except_tval : 32'd0;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (~i_stall && i_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_csr_wr) begin
            case (i_csr_addr)
                c_CSR_MSTATUS: begin
                    r_mstatus_mie  <= w_wval[c_MSTATUS_MIE_BIT];
                    r_mstatus_mpie <= w_wval[c_MSTATUS_MPIE_BIT];
                end
                c_CSR_MIE:      r_mie      <= w_wval & c_IRQ_MASK;
                c_CSR_MTVEC:    r_mtvec    <= w_wval & ~32'h2;
                c_CSR_MSCRATCH: r_mscratch <= w_wval;
                c_CSR_MEPC:     r_mepc     <= w_wval;
                c_CSR_MCAUSE:   r_mcause   <= w_wval;
                c_CSR_MTVAL:    r_mtval    <= w_wval;
                default:        ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (1'b1),
        .i_wr_lo (w_csr_wr && (i_csr_addr == c_CSR_MCYCLE)),
        .i_wr_hi (w_csr_wr && (i_csr_addr == c_CSR_MCYCLEH)),
        .i_wdata (w_wval),
        .o_count (w_cycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (i_retire & ~i_stall),
        .i_wr_lo (w_csr_wr && (i_csr_addr == c_CSR_MINSTRET)),
        .i_wr_hi (w_csr_wr && (i_csr_addr == c_CSR_MINSTRETH)),
        .i_wdata (w_wval),
        .o_count (w_instret)
    );
`else
    assign w_unused_retire = i_retire;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_csr_trap_unit
// Description : Self-checking bench for csr_trap_unit: directed scenarios
//               with literal expectations followed by randomized traffic
//               compared every cycle against a behavioural CSR model.
//               Honours CSR_COUNTERS_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        reset, stall, csr_we, except_en, mret, retire;
    logic        irq_ext, irq_timer, irq_soft;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [31:0] rs1_data, except_pc, except_tval;
    logic [4:0]  zimm;
    logic [3:0]  except_code;
    logic [31:0] o_csr_rdata, o_trap_vector, o_epc;
    logic        o_illegal, o_irq_take;

    int n_cmp = 0;
    int n_err = 0;

    csr_trap_unit #(
        .HART_ID     (32'd0),
        .MTVEC_RESET (32'h0000_0000),
        .MISA_VALUE  (32'h4000_0100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_stall       (stall),
        .i_csr_addr    (csr_addr),
        .i_csr_op      (csr_op),
        .i_csr_we      (csr_we),
        .i_rs1_data    (rs1_data),
        .i_zimm        (zimm),
        .o_csr_rdata   (o_csr_rdata),
        .o_illegal     (o_illegal),
        .i_except_en   (except_en),
        .i_except_code (except_code),
        .i_except_pc   (except_pc),
        .i_except_tval (except_tval),
        .i_mret        (mret),
        .i_retire      (retire),
        .i_irq_ext     (irq_ext),
        .i_irq_timer   (irq_timer),
        .i_irq_soft    (irq_soft),
        .o_irq_take    (o_irq_take),
        .o_trap_vector (o_trap_vector),
        .o_epc         (o_epc)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid = 0;
    bit          m_mie_b, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mie_r, m_mscratch;
    logic [63:0] m_cyc, m_ins;

    function automatic bit m_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
            12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hB80, 12'hB02, 12'hB82,
            12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_mip();
        return (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_soft) << 3);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mie_b) << 3) | (32'(m_mpie) << 7);
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie_r;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip();
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_src();
        return csr_op[2] ? {27'd0, zimm} : rs1_data;
    endfunction

    function automatic bit m_wants();
        case (csr_op)
            3'd1, 3'd5:             return 1;
            3'd2, 3'd3, 3'd6, 3'd7: return m_src() != 0;
            default:                return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_newval();
        logic [31:0] old = m_read(csr_addr);
        case (csr_op)
            3'd1, 3'd5: return m_src();
            3'd2, 3'd6: return old | m_src();
            default:    return old & ~m_src();
        endcase
    endfunction

    function automatic bit m_illegal();
        return csr_we && (!m_impl(csr_addr) || (csr_addr[11:10] == 2'b11 && m_wants()));
    endfunction

    function automatic bit m_take();
        return !stall && !except_en && m_mie_b && ((m_mie_r & m_mip()) != 0);
    endfunction

    function automatic logic [3:0] m_irq_code();
        logic [31:0] p = m_mie_r & m_mip();
        int order[3] = '{11, 3, 7};
        foreach (order[k]) if (p[order[k]]) return 4'(order[k]);
        return 4'd0;
    endfunction

    // Model state advance at each rising edge
    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1;
            m_mie_b = 0; m_mpie = 0;
            m_mtvec = 32'h0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_mie_r = 0; m_mscratch = 0; m_cyc = 0; m_ins = 0;
        end else if (m_valid) begin
            logic [63:0] ncyc, nins;
            bit take;
            take = m_take();
            ncyc = m_cyc + 1;
            nins = (retire && !stall) ? m_ins + 1 : m_ins;
            if (stall) begin
            end else if (except_en || take) begin
                m_mepc   = except_pc & ~32'h3;
                m_mcause = except_en ? {28'd0, except_code} : {1'b1, 27'd0, m_irq_code()};
                m_mtval  = except_en ? except_tval : 32'd0;
                m_mpie   = m_mie_b;
                m_mie_b  = 0;
            end else if (mret) begin
                m_mie_b = m_mpie;
                m_mpie  = 1;
            end else if (csr_we && m_wants() && !m_illegal()) begin
                logic [31:0] v;
                v = m_newval();
                case (csr_addr)
                    12'h300: begin m_mie_b = v[3]; m_mpie = v[7]; end
                    12'h304: m_mie_r    = v & 32'h888;
                    12'h305: m_mtvec    = v & ~32'h2;
                    12'h340: m_mscratch = v;
                    12'h341: m_mepc     = v;
                    12'h342: m_mcause   = v;
                    12'h343: m_mtval    = v;
                    12'hB00: ncyc = {m_cyc[63:32], v};
                    12'hB80: ncyc = {v, m_cyc[31:0]};
                    12'hB02: nins = {m_ins[63:32], v};
                    12'hB82: nins = {v, m_ins[31:0]};
                    default: ;
                endcase
            end
            m_cyc = ncyc;
            m_ins = nins;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        #3;
        if (m_valid) begin
            logic [31:0] base, tv;
            base = m_mtvec & ~32'h3;
            tv   = (m_take() && m_mtvec[0]) ? base + 4 * 32'(m_irq_code()) : base;
            chk("model rdata",    o_csr_rdata,          m_read(csr_addr));
            chk("model illegal",  32'(o_illegal),       32'(m_illegal()));
            chk("model irq_take", 32'(o_irq_take),      32'(m_take()));
            chk("model trap_vec", o_trap_vector,        tv);
            chk("model epc",      o_epc,                m_mepc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        reset = 0; stall = 0; csr_we = 0; except_en = 0; mret = 0; retire = 0;
        irq_ext = 0; irq_timer = 0; irq_soft = 0;
        csr_addr = 12'h300; csr_op = 3'd0; rs1_data = 0; zimm = 0;
        except_code = 0; except_pc = 0; except_tval = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
        cyc();
        csr_addr = a;
        #1;
        chk(nm, o_csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
        cyc();
        csr_we = 1; csr_addr = a; csr_op = op; rs1_data = d; zimm = d[4:0];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [11:0] addr_tab [23] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
        12'h341, 12'h342, 12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14,
        12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
        12'h7C0, 12'h300};
    logic [3:0] code_tab [3] = '{4'd2, 4'd3, 4'd11};

    initial begin
        idle();
        cyc(); reset = 1;

        // Reset values and read-only protection
        rd(12'h305, 32'h0000_0000, "reset mtvec");
        rd(12'h300, 32'h0000_1800, "reset mstatus");
        rd(12'hF14, 32'h0000_0000, "reset mhartid");
        chk("reset epc", o_epc, 32'h0);
        wr(12'hF14, 3'd1, 32'h55); #1;
        chk("mhartid write illegal", 32'(o_illegal), 32'd1);
        rd(12'hF14, 32'h0, "mhartid unchanged");

        // Exception entry and mret
        wr(12'h300, 3'd6, 32'd8); #1;
        chk("csrrsi legal", 32'(o_illegal), 32'd0);
        rd(12'h300, 32'h0000_1808, "mstatus MIE set");
        cyc(); except_en = 1; except_code = 4'd11; except_pc = 32'h102; except_tval = 32'h1234; #1;
        chk("ecall trap_vector", o_trap_vector, 32'h0);
        rd(12'h341, 32'h100, "ecall mepc");
        rd(12'h342, 32'd11, "ecall mcause");
        rd(12'h300, 32'h0000_1880, "ecall mstatus");
        rd(12'h343, 32'h1234, "ecall mtval");
        cyc(); mret = 1;
        rd(12'h300, 32'h0000_1888, "mret mstatus");

        // Vectored interrupt, MEI beats MTI
        wr(12'h305, 3'd1, 32'h8000_0001);
        wr(12'h304, 3'd1, 32'h0000_0880);
        rd(12'h305, 32'h8000_0001, "mtvec written");
        rd(12'h304, 32'h0000_0880, "mie written");
        cyc(); irq_timer = 1; irq_ext = 1; except_pc = 32'h200; #1;
        chk("irq_take", 32'(o_irq_take), 32'd1);
        chk("irq trap_vector", o_trap_vector, 32'h8000_002C);
        rd(12'h342, 32'h8000_000B, "irq mcause");
        rd(12'h343, 32'h0, "irq mtval");
        rd(12'h341, 32'h200, "irq mepc");

        // Exception beats interrupt; stall blocks everything
        wr(12'h300, 3'd6, 32'd8);
        cyc(); except_en = 1; except_code = 4'd3; except_pc = 32'h304;
        except_tval = 32'hDEAD; irq_ext = 1; #1;
        chk("exc over irq take", 32'(o_irq_take), 32'd0);
        chk("exc trap_vector", o_trap_vector, 32'h8000_0000);
        rd(12'h342, 32'd3, "exc mcause");
        rd(12'h343, 32'hDEAD, "exc mtval");
        cyc(); stall = 1; except_en = 1; except_code = 4'd11; except_pc = 32'h500;
        csr_we = 1; csr_addr = 12'h340; csr_op = 3'd1; rs1_data = 32'hAA; mret = 1;
        rd(12'h342, 32'd3, "stall mcause held");
        rd(12'h340, 32'h0, "stall mscratch held");
        chk("stall epc held", o_epc, 32'h304);

        // Unimplemented addresses
        cyc(); csr_we = 1; csr_addr = 12'h7C0; csr_op = 3'd2; #1;
        chk("unimpl rdata", o_csr_rdata, 32'h0);
        chk("unimpl illegal", 32'(o_illegal), 32'd1);
`ifdef CSR_COUNTERS_EN
        wr(12'hB80, 3'd1, 32'h5);
        wr(12'hB00, 3'd1, 32'hFFFF_FFFF);
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle written");
        rd(12'hB80, 32'h6, "mcycleh carry");
        wr(12'hB02, 3'd1, 32'h10);
        wr(12'hB82, 3'd1, 32'h77); retire = 1;
        rd(12'hB02, 32'h10, "minstret low held");
        rd(12'hB82, 32'h77, "minstreth written");
`else
        cyc(); csr_we = 1; csr_addr = 12'hB00; csr_op = 3'd1; #1;
        chk("no-counter rdata", o_csr_rdata, 32'h0);
        chk("no-counter illegal", 32'(o_illegal), 32'd1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset       = ($urandom_range(0, 99) < 2);
            stall       = ($urandom_range(0, 9) == 0);
            csr_we      = ($urandom_range(0, 9) < 6);
            csr_addr    = ($urandom_range(0, 9) == 0) ? 12'($urandom)
                                                      : addr_tab[$urandom_range(0, 22)];
            csr_op      = 3'($urandom_range(0, 7));
            rs1_data    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            zimm        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            except_en   = ($urandom_range(0, 9) == 0);
            except_code = code_tab[$urandom_range(0, 2)];
            except_pc   = $urandom;
            except_tval = $urandom;
            mret        = ($urandom_range(0, 9) == 0);
            retire      = 1'($urandom_range(0, 1));
            irq_ext     = ($urandom_range(0, 3) == 0);
            irq_timer   = ($urandom_range(0, 3) == 0);
            irq_soft    = ($urandom_range(0, 3) == 0);
        end
        cyc();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
